pattern_source_fifo_writer: RTL and testbench
=============================================

Name: pattern_source_fifo_writer

Overview:
- Transmit-side counterpart of the pipe-in data checker.
- Generates a deterministic 32-bit test pattern and writes it into the pipe-out FIFO (FIFO_32bit) at full okClk rate, honouring FIFO backpressure.
- Host then drains the FIFO through the 0xA0 pipe-out and checks the data.
- Counts words written and stall cycles, reported on wire-outs for throughput and backpressure measurement.

Parameters:
DATA_WIDTH, 32, pattern/FIFO data width
COUNT_WIDTH, 32, width of word_count, words_written and stall_cycles
LFSR_TAPS, 32'h80200003, Galois LFSR feedback mask (x^32+x^22+x^2+x+1)

Ports:
okClk  input  1  sole clock; all logic on rising edge
reset  input  1  synchronous, active-high; from trigger bit 0
start  input  1  one-cycle pulse (trigger); begins a run
abort  input  1  one-cycle pulse (trigger); ends a run early
reset_pattern  input  1  one-cycle pulse; reloads pattern register from seed
mode  input  3  pattern select (wire-in bits [2:0])
seed  input  DATA_WIDTH  pattern seed (wire-in)
word_count  input  COUNT_WIDTH  words to write per run (wire-in)
fifo_full  input  1  FIFO full flag
fifo_din  output  DATA_WIDTH  FIFO write data
fifo_wr_en  output  1  FIFO write enable
busy  output  1  high in RUN
done  output  1  high in DONE
words_written  output  COUNT_WIDTH  writes accepted this run
stall_cycles  output  COUNT_WIDTH  RUN cycles with fifo_full high

Behaviour:
- States:
  - IDLE, RUN and DONE.
  - reset forces IDLE and clears pattern register, words_written and stall_cycles to 0. busy=0, done=0, fifo_wr_en=0, fifo_din=0.
- IDLE or DONE + start:
  - Latch mode, seed and word_count.
  - Load pattern register with the mode's initial value.
  - Clear both counters.
  - Next state RUN, or DONE directly if word_count==0.
- start while in RUN is ignored.
- RUN write rules:
  - fifo_wr_en = (state==RUN) && !fifo_full, combinational.
  - fifo_din = pattern register, zero latency.
  - Each cycle with fifo_wr_en=1: pattern advances and words_written increments.
  - When the increment makes words_written equal to the latched count, next state is DONE.
  - Each RUN cycle with fifo_full=1: stall_cycles increments and the pattern holds.
- abort in RUN: next state DONE, counters frozen. If abort coincides with a write, that write still completes and is counted.
- abort outside RUN is ignored.
- reset_pattern:
  - In IDLE/DONE, reloads the pattern register only.
  - Ignored in RUN.
- reset has priority over every other input. Reset mid-run takes effect next edge with no further writes.
- Patterns (initial value -> advance):
  - 0 counter: seed -> +1, wraps modulo 2^32.
  - 1 LFSR: seed (0 replaced by 1) -> (p>>1) ^ (p[0] ? LFSR_TAPS : 0).
  - 2 walking one: 0x00000001 (seed ignored) -> rotate left 1.
  - 3 alternating: seed -> bitwise invert.
  - 4-7 fixed: seed -> no change.
- DONE:
  - Holds counters; done=1.
  - Only reset or start leaves DONE.
- Counters saturate at all-ones, never wrap.

Test Plan:
- Counter: mode=0, seed=0x10, word_count=4, fifo_full=0, start -> fifo_wr_en high 4 consecutive cycles with din 0x10,0x11,0x12,0x13. DONE next cycle; words_written=4, stall_cycles=0.
- LFSR: mode=1, seed=1, count=3 -> din 0x00000001, 0x80200003, 0xC0300002. Repeat with seed=0 -> identical sequence.
- Backpressure:
  - Setup: mode=0, seed=0, count=4; fifo_full high on the 2nd and 3rd RUN cycles.
  - Required: din holds 0x1 while full and wr_en is low. Writes are 0,1,2,3 over 6 cycles; stall_cycles=2, words_written=4.
- Walking one: mode=2, count=33 -> 0x1, 0x2, ..., 0x80000000, 0x1 (wrap on 33rd). Mode=3, seed=0xA5A5A5A5 -> 0xA5A5A5A5, 0x5A5A5A5A, 0xA5A5A5A5.
- Abort/reset:
  - Abort after 2 writes of count=10 -> DONE, words_written=2, no further wr_en.
  - Reset mid-run -> IDLE, all outputs 0 next cycle.
  - start with word_count=0 -> DONE directly, no writes.
- Ignored pulses: start during RUN -> no restart, sequence continues. reset_pattern in DONE with mode=0, seed=0x55 -> fifo_din=0x55, counters unchanged.

Source files
------------

// File: rtl/pattern_source_fifo_writer.sv
// Writes a deterministic 32-bit test pattern into the pipe-out FIFO at full okClk rate.
// It stalls on fifo_full and counts both the words written and the stalled cycles.
module pattern_source_fifo_writer #(
  parameter int                      DATA_WIDTH  = 32,
  parameter int                      COUNT_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]   LFSR_TAPS   = 32'h80200003
) (
  input  logic                   okClk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   reset_pattern,
  input  logic [2:0]             mode,
  input  logic [DATA_WIDTH-1:0]  seed,
  input  logic [COUNT_WIDTH-1:0] word_count,
  input  logic                   fifo_full,
  output logic [DATA_WIDTH-1:0]  fifo_din,
  output logic                   fifo_wr_en,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] words_written,
  output logic [COUNT_WIDTH-1:0] stall_cycles
);

  // state | meaning
  // IDLE  | waiting for start after reset; pattern may be reloaded
  // RUN   | writing one word per cycle unless the FIFO is full
  // DONE  | run finished or aborted; counters held for readback
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  logic [DATA_WIDTH-1:0]  pattern;
  logic [2:0]             run_mode;
  logic [COUNT_WIDTH-1:0] run_count;
  logic [COUNT_WIDTH-1:0] words_next;

  function automatic logic [DATA_WIDTH-1:0] pattern_init(input logic [2:0]            m,
                                                         input logic [DATA_WIDTH-1:0] s);
    case (m)
      3'd1:    return (s == '0) ? DATA_WIDTH'(1) : s;
      3'd2:    return DATA_WIDTH'(1);
      default: return s;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pattern_next(input logic [2:0]            m,
                                                         input logic [DATA_WIDTH-1:0] p);
    case (m)
      3'd0:    return p + DATA_WIDTH'(1);
      3'd1:    return (p >> 1) ^ (p[0] ? LFSR_TAPS : '0);
      3'd2:    return {p[DATA_WIDTH-2:0], p[DATA_WIDTH-1]};
      3'd3:    return ~p;
      default: return p;
    endcase
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] c);
    return (&c) ? c : c + COUNT_WIDTH'(1);
  endfunction

  // busy mirrors state==RUN, so the write strobe stays a single gate off the FIFO flag
  assign fifo_wr_en = busy && !fifo_full;
  assign fifo_din   = pattern;
  assign words_next = sat_inc(words_written);

  always_ff @(posedge okClk) begin
    if (reset) begin
      state         <= IDLE;
      pattern       <= '0;
      run_mode      <= '0;
      run_count     <= '0;
      words_written <= '0;
      stall_cycles  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            run_mode      <= mode;
            run_count     <= word_count;
            pattern       <= pattern_init(mode, seed);
            words_written <= '0;
            stall_cycles  <= '0;
            if (word_count == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end else if (reset_pattern) begin
            pattern <= pattern_init(mode, seed);
          end
        end
        RUN: begin
          if (fifo_wr_en) begin
            pattern       <= pattern_next(run_mode, pattern);
            words_written <= words_next;
          end else begin
            stall_cycles  <= sat_inc(stall_cycles);
          end
          // a write in the abort cycle still lands, so only the state changes here
          if (abort || (fifo_wr_en && words_next == run_count)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_source_fifo_writer.sv
// Randomized and directed bench for pattern_source_fifo_writer.
// A scoreboard queue of expected FIFO words is filled at start and drained by a monitor.
module tb_pattern_source_fifo_writer;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic        okClk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        reset_pattern = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic [31:0] seed = 32'h0;
  logic [31:0] word_count = 32'h0;
  logic        fifo_full = 1'b0;
  logic [31:0] fifo_din;
  logic        fifo_wr_en;
  logic        busy;
  logic        done;
  logic [31:0] words_written;
  logic [31:0] stall_cycles;

  pattern_source_fifo_writer dut (
    .okClk(okClk), .reset(reset), .start(start), .abort(abort),
    .reset_pattern(reset_pattern), .mode(mode), .seed(seed),
    .word_count(word_count), .fifo_full(fifo_full), .fifo_din(fifo_din),
    .fifo_wr_en(fifo_wr_en), .busy(busy), .done(done),
    .words_written(words_written), .stall_cycles(stall_cycles)
  );

  always #5 okClk = ~okClk;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  // reference model: pattern is the k-th term of a sequence, not a stepped register
  int          m_st = M_IDLE;
  bit          m_zero = 1'b1;
  int unsigned m_bmode = 0;
  logic [31:0] m_bseed = 32'h0;
  int unsigned m_steps = 0;
  int unsigned m_count = 0;
  int unsigned m_written = 0;
  int unsigned m_stalls = 0;
  logic [31:0] sbq[$];

  function automatic logic [31:0] gen(input int unsigned md, input logic [31:0] sd,
                                      input int unsigned k);
    logic [31:0] p;
    case (md)
      0: return sd + k;
      1: begin
        p = (sd == 32'h0) ? 32'h1 : sd;
        for (int i = 0; i < int'(k); i++) p = (p >> 1) ^ (p[0] ? 32'h80200003 : 32'h0);
        return p;
      end
      2: return 32'h1 << (k % 32);
      3: return k[0] ? ~sd : sd;
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] model_pat();
    return m_zero ? 32'h0 : gen(m_bmode, m_bseed, m_steps);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_st = M_IDLE; m_zero = 1'b1; m_steps = 0; m_written = 0; m_stalls = 0;
      sbq.delete();
    end else if (m_st == M_RUN) begin
      if (!fifo_full) begin
        m_steps++;
        m_written++;
        if (m_written == m_count) m_st = M_DONE;
      end else begin
        m_stalls++;
      end
      if (abort) m_st = M_DONE;
      if (m_st == M_DONE) sbq.delete();
    end else if (start) begin
      m_bmode = mode; m_bseed = seed; m_steps = 0; m_zero = 1'b0;
      m_count = word_count; m_written = 0; m_stalls = 0;
      sbq.delete();
      for (int k = 0; k < int'(word_count); k++) sbq.push_back(gen(mode, seed, k));
      m_st = (word_count == 0) ? M_DONE : M_RUN;
    end else if (reset_pattern) begin
      m_bmode = mode; m_bseed = seed; m_steps = 0; m_zero = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge okClk);
    model_step();
    #1;
    start = 1'b0; abort = 1'b0; reset_pattern = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_start(input logic [2:0] md, input logic [31:0] sd, input logic [31:0] wc);
    mode = md; seed = sd; word_count = wc; start = 1'b1;
    tick();
  endtask

  always @(negedge okClk) begin
    if (mon_en) begin
      chk("wr_en", {31'h0, fifo_wr_en}, {31'h0, (m_st == M_RUN) && !fifo_full});
      chk("busy", {31'h0, busy}, {31'h0, m_st == M_RUN});
      chk("done", {31'h0, done}, {31'h0, m_st == M_DONE});
      chk("din", fifo_din, model_pat());
      chk("words_written", words_written, m_written);
      chk("stall_cycles", stall_cycles, m_stalls);
      if (fifo_wr_en === 1'b1) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: got data %h expected no write", fifo_din);
        end else begin
          chk("write_data", fifo_din, sbq.pop_front());
        end
      end
    end
  end

  initial begin
    tick();
    mon_en = 1'b1;
    ticks(2);
    reset = 1'b0;
    ticks(2);

    run_start(3'd0, 32'h10, 32'd4);           ticks(6);
    run_start(3'd1, 32'h1, 32'd3);            ticks(5);
    run_start(3'd1, 32'h0, 32'd3);            ticks(5);

    run_start(3'd0, 32'h0, 32'd4);
    tick();
    fifo_full = 1'b1; ticks(2);
    fifo_full = 1'b0; ticks(5);

    run_start(3'd2, 32'hFFFF_0000, 32'd33);   ticks(36);
    run_start(3'd3, 32'hA5A5_A5A5, 32'd3);    ticks(5);

    run_start(3'd0, 32'h0, 32'd10);
    ticks(2);
    fifo_full = 1'b1; abort = 1'b1; tick();
    fifo_full = 1'b0; ticks(4);
    run_start(3'd4, 32'hDEAD_BEEF, 32'd10);
    ticks(2);
    abort = 1'b1; tick();
    ticks(4);

    run_start(3'd0, 32'h100, 32'd10);
    ticks(3);
    reset = 1'b1; tick();
    reset = 1'b0; ticks(3);

    run_start(3'd0, 32'h7, 32'd0);            ticks(3);

    run_start(3'd0, 32'h100, 32'd8);
    ticks(2);
    mode = 3'd3; seed = 32'h1234; start = 1'b1; tick();
    ticks(8);
    mode = 3'd0; seed = 32'h55; reset_pattern = 1'b1; tick();
    ticks(2);
    abort = 1'b1; tick();
    ticks(2);

    for (int r = 0; r < 40; r++) begin
      logic [31:0] rs;
      rs = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      run_start(3'($urandom_range(0, 7)), rs, 32'($urandom_range(0, 40)));
      for (int c = 0; c < 200 && m_st == M_RUN; c++) begin
        fifo_full = ($urandom_range(0, 3) == 0);
        abort = ($urandom_range(0, 49) == 0);
        reset_pattern = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 19) == 0) begin
          start = 1'b1; seed = $urandom; mode = 3'($urandom_range(0, 7));
        end
        reset = ($urandom_range(0, 299) == 0);
        tick();
        reset = 1'b0;
      end
      fifo_full = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 1) == 0) begin
        mode = 3'($urandom_range(0, 7)); seed = $urandom; reset_pattern = 1'b1;
      end
      abort = ($urandom_range(0, 3) == 0);
      tick();
      fifo_full = 1'b0;
      ticks(2);
    end

    ticks(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
